// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller.
// FSM state encodings, state width and the counter-width helper.
package serial_add_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit-counter width; a 1-bit counter is kept for the smallest legal width.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// master drives start/operands, slave returns busy/done/results.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_ctrl_onebit_fa.sv
// One-bit full-adder cell: the single bit-slice stepped by the controller.
module onebit_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one bit per clock, LSB first, through onebit_fa.
// Optional signed-overflow flag built only when SERIAL_ADD_OVF_EN is defined.
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_adder_ctrl_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] sum_sh_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             ovf_bit;

    logic             load;
    logic             step;
    logic             last;
    logic             busy_c;
    logic             done_c;
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_sh_next;

    onebit_fa u_fa (
        .a  (a_sh_reg[0]),
        .b  (b_sh_reg[0]),
        .ci (carry_reg),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_c = 1'b1;
                step   = 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    last       = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_c     = 1'b1;
                done_c     = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // New sum bits enter at the MSB so the LSB-first stream lands in place.
    assign sum_sh_next = {fa_s, sum_sh_reg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sum_sh_reg <= '0;
            sum_reg    <= '0;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            cout_reg   <= 1'b0;
        end else if (load) begin
            a_sh_reg   <= bus.a;
            b_sh_reg   <= bus.sub ? ~bus.b : bus.b;
            carry_reg  <= bus.sub ? 1'b1 : bus.cin;
            sum_sh_reg <= '0;
            cnt_reg    <= '0;
        end else if (step) begin
            a_sh_reg   <= a_sh_reg >> 1;
            b_sh_reg   <= b_sh_reg >> 1;
            sum_sh_reg <= sum_sh_next;
            carry_reg  <= fa_co;
            cnt_reg    <= cnt_reg + CW'(1);
            if (last) begin
                sum_reg  <= sum_sh_next;
                cout_reg <= fa_co;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_reg;

    // During the last RUN step carry_reg is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (step && last) begin
            ovf_reg <= carry_reg ^ fa_co;
        end
    end

    assign ovf_bit = ovf_reg;
`else
    assign ovf_bit = 1'b0;
`endif

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
    assign bus.ovf  = ovf_bit;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: arithmetic reference model plus directed pins.
// Honors SERIAL_ADD_OVF_EN for the expected overflow flag.
module tb_serial_adder_ctrl;

    localparam int W = 8;
`ifdef SERIAL_ADD_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_count = 0;
    int   done_cyc[$];
    logic [W-1:0] done_sum[$];

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: operations take W+1 cycles after acceptance, done on the last.
    int           left = 0;
    bit           model_en = 1'b0;
    logic [W-1:0] p_sum, m_sum;
    logic         p_cout, p_ovf, m_cout, m_ovf, m_busy, m_done;

    always @(posedge clk) begin
        logic [W:0]   full;
        logic [W-1:0] bb;
        logic         cy;
        cyc++;
        if (!rst_n) begin
            left = 0; model_en = 1'b1;
            m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
        end else if (left == 0) begin
            if (bus.start) begin
                bb    = bus.sub ? ~bus.b : bus.b;
                cy    = bus.sub ? 1'b1 : bus.cin;
                full  = {1'b0, bus.a} + {1'b0, bb} + {{W{1'b0}}, cy};
                p_sum = full[W-1:0];
                p_cout = full[W];
                p_ovf = OVF_ON && (bus.a[W-1] == bb[W-1]) && (full[W-1] != bus.a[W-1]);
                left  = W + 1;
            end
        end else begin
            left--;
            if (left == 1) begin
                m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
            end
        end
        m_busy = (left != 0);
        m_done = (left == 1);
    end

    always @(negedge clk) begin
        if (model_en) begin
            chk("busy", {31'd0, bus.busy}, {31'd0, m_busy});
            chk("done", {31'd0, bus.done}, {31'd0, m_done});
            chk("sum",  {24'd0, bus.sum},  {24'd0, m_sum});
            chk("cout", {31'd0, bus.cout}, {31'd0, m_cout});
            chk("ovf",  {31'd0, bus.ovf},  {31'd0, m_ovf});
            if (bus.done === 1'b1) begin
                done_count++;
                done_cyc.push_back(cyc);
                done_sum.push_back(bus.sum);
            end
        end
    end

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
        int guard = 0;
        while (bus.busy === 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (bus.busy !== 1'b0) chk("idle_timeout", 32'd1, 32'd0);
        bus.a = ta; bus.b = tb; bus.cin = tc; bus.sub = ts; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom);
        bus.cin = 1'($urandom); bus.sub = 1'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < W + 6; i++) begin
            if (bus.done === 1'b1) return;
            @(negedge clk);
        end
        chk("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic pin(input string nm, input logic [W-1:0] es, input logic ec, input logic eo);
        wait_done();
        chk({nm, "_sum"},  {24'd0, bus.sum},  {24'd0, es});
        chk({nm, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
        chk({nm, "_ovf"},  {31'd0, bus.ovf},  {31'd0, eo & OVF_ON});
        $display("op %s sum=0x%02h cout=%0b ovf=%0b", nm, bus.sum, bus.cout, bus.ovf);
    endtask

    initial begin
        int base;
        int s0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_sum",  {24'd0, bus.sum},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'h5A, 8'h33, 1'b0, 1'b0);
        chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        pin("5A+33", 8'h8D, 1'b0, 1'b1);
        issue(8'hFF, 8'h01, 1'b0, 1'b0); pin("FF+01", 8'h00, 1'b1, 1'b0);
        issue(8'h00, 8'h00, 1'b1, 1'b0); pin("00+00+c", 8'h01, 1'b0, 1'b0);
        issue(8'h10, 8'h20, 1'b0, 1'b1); pin("10-20", 8'hF0, 1'b0, 1'b0);
        issue(8'h80, 8'h01, 1'b0, 1'b1); pin("80-01", 8'h7F, 1'b1, 1'b1);

        // start pulse during RUN must be ignored
        @(negedge clk);
        base = done_count;
        issue(8'h01, 8'h01, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        bus.a = 8'hFF; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        pin("ignored_start", 8'h02, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("single_done", done_count - base, 32'd1);

        // reset on RUN cycle 4 aborts
        base = done_count;
        issue(8'h77, 8'h11, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_sum",  {24'd0, bus.sum},  32'd0);
        chk("abort_cout", {31'd0, bus.cout}, 32'd0);
        repeat (15) @(negedge clk);
        chk("abort_no_done", done_count - base, 32'd0);
        $display("op abort busy=%0b sum=0x%02h", bus.busy, bus.sum);

        // start held high: back-to-back operations
        done_cyc.delete(); done_sum.delete();
        bus.a = 8'h3C; bus.b = 8'h4B; bus.cin = 1'b1; bus.sub = 1'b0; bus.start = 1'b1;
        repeat (30) @(negedge clk);
        bus.start = 1'b0;
        repeat (W + 4) @(negedge clk);
        chk("held_done_count_ge3", {31'd0, done_cyc.size() >= 3}, 32'd1);
        s0 = done_cyc.size();
        for (int i = 1; i < s0; i++) begin
            chk("held_spacing", done_cyc[i] - done_cyc[i-1], W + 2);
            chk("held_sum", {24'd0, done_sum[i]}, 32'h88);
        end
        $display("op held dones=%0d", s0);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            logic [W-1:0] ra, rb;
            logic rc, rs;
            ra = W'($urandom); rb = W'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            issue(ra, rb, rc, rs);
            wait_done();
            $display("op rnd%0d a=0x%02h b=0x%02h cin=%0b sub=%0b sum=0x%02h cout=%0b ovf=%0b",
                     n, ra, rb, rc, rs, bus.sum, bus.cout, bus.ovf);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
